// File: rtl/match_controller.sv
// rtl/match_controller.sv - air-hockey match sequencing: serve, play, goal, game over, BCD scores
// Optional PAUSE state from PLAY is built when MATCH_PAUSE_EN is defined.
module match_controller #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int GOAL_FRAMES  = 90
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btns,
    input  logic       goal_p1,
    input  logic       goal_p2,
    output logic       play_en,
    output logic       puck_reset,
    output logic       serve_dir,
    output logic [3:0] p1_ones,
    output logic [2:0] p1_tens,
    output logic [3:0] p2_ones,
    output logic [2:0] p2_tens,
    output logic [1:0] winner,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_GOAL  = 3'd3,
        S_OVER  = 3'd4,
        S_PAUSE = 3'd5
    } state_t;

    localparam logic [3:0] WIN_ONES   = 4'(WIN_SCORE % 10);
    localparam logic [2:0] WIN_TENS   = 3'(WIN_SCORE / 10);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] GOAL_LAST  = 8'(GOAL_FRAMES - 1);

    state_t     st;
    logic [7:0] frame_cnt;
    logic       btn_q;
    logic       btn_prev;
    logic       btn_armed;
    logic       press;
    logic       p1_win;
    logic       p2_win;

    // btn_armed stays low until the button is seen released, so a button
    // held through reset never registers as a press.
    assign press  = btn_q & ~btn_prev & btn_armed;
    assign p1_win = (p1_ones == WIN_ONES) && (p1_tens == WIN_TENS);
    assign p2_win = (p2_ones == WIN_ONES) && (p2_tens == WIN_TENS);
    assign state  = st;

    function automatic logic [6:0] bcd_inc(input logic [2:0] tens, input logic [3:0] ones);
        if (ones == 4'd9)
            return {tens + 3'd1, 4'd0};
        else
            return {tens, ones + 4'd1};
    endfunction

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            st         <= S_IDLE;
            frame_cnt  <= 8'd0;
            btn_q      <= 1'b0;
            btn_prev   <= 1'b0;
            btn_armed  <= 1'b0;
            play_en    <= 1'b0;
            puck_reset <= 1'b0;
            serve_dir  <= 1'b0;
            p1_ones    <= 4'd0;
            p1_tens    <= 3'd0;
            p2_ones    <= 4'd0;
            p2_tens    <= 3'd0;
            winner     <= 2'b00;
        end else begin
            btn_q      <= btns;
            btn_prev   <= btn_q;
            btn_armed  <= btn_armed | ~btns;
            puck_reset <= 1'b0;
            case (st)
                S_IDLE, S_OVER: begin
                    if (press) begin
                        st         <= S_SERVE;
                        frame_cnt  <= 8'd0;
                        puck_reset <= 1'b1;
                        p1_ones    <= 4'd0;
                        p1_tens    <= 3'd0;
                        p2_ones    <= 4'd0;
                        p2_tens    <= 3'd0;
                        winner     <= 2'b00;
                    end
                end
                S_SERVE: begin
                    if (frame_tick) begin
                        if (frame_cnt == SERVE_LAST) begin
                            st        <= S_PLAY;
                            play_en   <= 1'b1;
                            frame_cnt <= 8'd0;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                S_PLAY: begin
                    // Simultaneous goals are treated as a void point and re-served.
                    if (goal_p1 && goal_p2) begin
                        st         <= S_SERVE;
                        play_en    <= 1'b0;
                        puck_reset <= 1'b1;
                        frame_cnt  <= 8'd0;
                    end else if (goal_p1) begin
                        st                 <= S_GOAL;
                        play_en            <= 1'b0;
                        serve_dir          <= 1'b1;
                        frame_cnt          <= 8'd0;
                        {p1_tens, p1_ones} <= bcd_inc(p1_tens, p1_ones);
                    end else if (goal_p2) begin
                        st                 <= S_GOAL;
                        play_en            <= 1'b0;
                        serve_dir          <= 1'b0;
                        frame_cnt          <= 8'd0;
                        {p2_tens, p2_ones} <= bcd_inc(p2_tens, p2_ones);
                    end
`ifdef MATCH_PAUSE_EN
                    else if (press) begin
                        st      <= S_PAUSE;
                        play_en <= 1'b0;
                    end
`endif
                end
                S_GOAL: begin
                    if (frame_tick) begin
                        if (frame_cnt == GOAL_LAST) begin
                            frame_cnt <= 8'd0;
                            if (p1_win) begin
                                st     <= S_OVER;
                                winner <= 2'b01;
                            end else if (p2_win) begin
                                st     <= S_OVER;
                                winner <= 2'b10;
                            end else begin
                                st         <= S_SERVE;
                                puck_reset <= 1'b1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
`ifdef MATCH_PAUSE_EN
                S_PAUSE: begin
                    if (press) begin
                        st      <= S_PLAY;
                        play_en <= 1'b1;
                    end
                end
`endif
                default: begin
                    st      <= S_IDLE;
                    play_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_controller.sv
// tb/tb_match_controller.sv - directed self-checking bench for match_controller
module tb_match_controller;

    logic       clk25 = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btns = 1'b0;
    logic       goal_p1 = 1'b0;
    logic       goal_p2 = 1'b0;

    logic       play_en, puck_reset, serve_dir;
    logic [3:0] p1_ones, p2_ones;
    logic [2:0] p1_tens, p2_tens;
    logic [1:0] winner;
    logic [2:0] state;

    logic       b_play_en, b_puck_reset, b_serve_dir;
    logic [3:0] b_p1_ones, b_p2_ones;
    logic [2:0] b_p1_tens, b_p2_tens;
    logic [1:0] b_winner;
    logic [2:0] b_state;

    int checks = 0;
    int errors = 0;

    match_controller dut (
        .clk25(clk25), .rst(rst), .frame_tick(frame_tick), .btns(btns),
        .goal_p1(goal_p1), .goal_p2(goal_p2), .play_en(play_en),
        .puck_reset(puck_reset), .serve_dir(serve_dir), .p1_ones(p1_ones),
        .p1_tens(p1_tens), .p2_ones(p2_ones), .p2_tens(p2_tens),
        .winner(winner), .state(state)
    );

    match_controller #(.WIN_SCORE(12)) dut12 (
        .clk25(clk25), .rst(rst), .frame_tick(frame_tick), .btns(btns),
        .goal_p1(goal_p1), .goal_p2(goal_p2), .play_en(b_play_en),
        .puck_reset(b_puck_reset), .serve_dir(b_serve_dir), .p1_ones(b_p1_ones),
        .p1_tens(b_p1_tens), .p2_ones(b_p2_ones), .p2_tens(b_p2_tens),
        .winner(b_winner), .state(b_state)
    );

    always #5 clk25 = ~clk25;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cycle();
        @(posedge clk25);
        #1;
    endtask

    // Leaves the bench sampling just after the edge that saw the last tick.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cycle();
            frame_tick = 1'b0;
            if (i != n - 1) cycle();
        end
    endtask

    task automatic press_hold();
        btns = 1'b1;
        cycle();
        cycle();
    endtask

    task automatic release_btn();
        btns = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    task automatic start_play();
        press_hold();
        release_btn();
        ticks(60);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if ({p1_tens, p1_ones, p2_tens, p2_ones} !== 14'd0) begin errors++; $display("FAIL reset_scores: got %0h expected 0", {p1_tens, p1_ones, p2_tens, p2_ones}); end
        checks++; if ({winner, serve_dir, play_en, puck_reset} !== 5'd0) begin errors++; $display("FAIL reset_flags: got %0b expected 00000", {winner, serve_dir, play_en, puck_reset}); end
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_serve();
        int bad;
        int pr;
        bad = 0;
        pr = 0;
        press_hold();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL press_state: got %0d expected 1", state); end
        checks++; if (puck_reset !== 1'b1) begin errors++; $display("FAIL press_puck_reset: got %0b expected 1", puck_reset); end
        btns = 1'b0;
        cycle();
        checks++; if (puck_reset !== 1'b0) begin errors++; $display("FAIL puck_reset_single: got %0b expected 0", puck_reset); end
        cycle();
        goal_p1 = 1'b1;
        cycle();
        goal_p1 = 1'b0;
        checks++; if (p1_ones !== 4'd0 || state !== 3'd1) begin errors++; $display("FAIL goal_in_serve: got score %0d state %0d expected 0 and 1", p1_ones, state); end
        for (int i = 0; i < 59; i++) begin
            frame_tick = 1'b1;
            cycle();
            frame_tick = 1'b0;
            if (state !== 3'd1 || play_en !== 1'b0) bad++;
            if (puck_reset) pr++;
            cycle();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL serve_hold_59: got %0d bad cycles expected 0", bad); end
        ticks(1);
        checks++; if (state !== 3'd2 || play_en !== 1'b1) begin errors++; $display("FAIL serve_to_play: got state %0d play_en %0b expected 2 and 1", state, play_en); end
        checks++; if (pr !== 0) begin errors++; $display("FAIL serve_puck_reset: got %0d pulses expected 0", pr); end
    endtask

    task automatic test_p1_match();
        for (int k = 1; k <= 7; k++) begin
            goal_p1 = 1'b1;
            cycle();
            goal_p1 = 1'b0;
            checks++; if (state !== 3'd3 || play_en !== 1'b0) begin errors++; $display("FAIL goal_state_%0d: got state %0d play_en %0b expected 3 and 0", k, state, play_en); end
            checks++; if (p1_ones !== 4'(k) || serve_dir !== 1'b1) begin errors++; $display("FAIL goal_score_%0d: got %0d dir %0b expected %0d and 1", k, p1_ones, serve_dir, k); end
            ticks(90);
            if (k < 7) begin
                checks++; if (state !== 3'd1 || puck_reset !== 1'b1) begin errors++; $display("FAIL goal_to_serve_%0d: got state %0d puck_reset %0b expected 1 and 1", k, state, puck_reset); end
                ticks(59);
                checks++; if (state !== 3'd1) begin errors++; $display("FAIL reserve_hold_%0d: got %0d expected 1", k, state); end
                ticks(1);
                checks++; if (state !== 3'd2 || play_en !== 1'b1) begin errors++; $display("FAIL reserve_play_%0d: got state %0d play_en %0b expected 2 and 1", k, state, play_en); end
            end else begin
                checks++; if (state !== 3'd4 || winner !== 2'b01) begin errors++; $display("FAIL match_over: got state %0d winner %0b expected 4 and 01", state, winner); end
                checks++; if (play_en !== 1'b0 || puck_reset !== 1'b0) begin errors++; $display("FAIL over_flags: got play_en %0b puck_reset %0b expected 0 and 0", play_en, puck_reset); end
            end
        end
        goal_p1 = 1'b1;
        cycle();
        goal_p1 = 1'b0;
        cycle();
        checks++; if (p1_ones !== 4'd7 || p2_ones !== 4'd0 || winner !== 2'b01 || state !== 3'd4) begin errors++; $display("FAIL over_hold: got p1 %0d p2 %0d winner %0b state %0d expected 7 0 01 4", p1_ones, p2_ones, winner, state); end
        press_hold();
        checks++; if (state !== 3'd1 || winner !== 2'b00 || p1_ones !== 4'd0 || puck_reset !== 1'b1) begin errors++; $display("FAIL over_restart: got state %0d winner %0b p1 %0d puck_reset %0b expected 1 00 0 1", state, winner, p1_ones, puck_reset); end
        release_btn();
    endtask

    task automatic test_bcd();
        do_reset();
        start_play();
        for (int k = 1; k <= 10; k++) begin
            goal_p2 = 1'b1;
            cycle();
            goal_p2 = 1'b0;
            if (k == 9) begin
                checks++; if (b_p2_ones !== 4'd9 || b_p2_tens !== 3'd0 || b_serve_dir !== 1'b0) begin errors++; $display("FAIL bcd_nine: got %0d%0d dir %0b expected 09 and 0", b_p2_tens, b_p2_ones, b_serve_dir); end
            end
            if (k == 10) begin
                checks++; if (b_p2_ones !== 4'd0 || b_p2_tens !== 3'd1 || b_state !== 3'd3) begin errors++; $display("FAIL bcd_carry: got %0d%0d state %0d expected 10 and 3", b_p2_tens, b_p2_ones, b_state); end
            end
            if (k < 10) begin
                ticks(90);
                if (k == 7) begin
                    checks++; if (state !== 3'd4 || winner !== 2'b10 || p2_ones !== 4'd7) begin errors++; $display("FAIL p2_wins: got state %0d winner %0b p2 %0d expected 4 10 7", state, winner, p2_ones); end
                end
                ticks(60);
            end
        end
    endtask

    task automatic test_both_goals();
        do_reset();
        start_play();
        goal_p1 = 1'b1;
        cycle();
        goal_p1 = 1'b0;
        ticks(90);
        ticks(60);
        goal_p1 = 1'b1;
        goal_p2 = 1'b1;
        cycle();
        goal_p1 = 1'b0;
        goal_p2 = 1'b0;
        checks++; if (state !== 3'd1 || puck_reset !== 1'b1 || play_en !== 1'b0) begin errors++; $display("FAIL both_state: got state %0d puck_reset %0b play_en %0b expected 1 1 0", state, puck_reset, play_en); end
        checks++; if (p1_ones !== 4'd1 || p2_ones !== 4'd0 || serve_dir !== 1'b1) begin errors++; $display("FAIL both_scores: got p1 %0d p2 %0d dir %0b expected 1 0 1", p1_ones, p2_ones, serve_dir); end
        cycle();
        checks++; if (puck_reset !== 1'b0) begin errors++; $display("FAIL both_pulse_width: got %0b expected 0", puck_reset); end
    endtask

    task automatic test_async_reset();
        do_reset();
        start_play();
        goal_p1 = 1'b1;
        cycle();
        goal_p1 = 1'b0;
        ticks(10);
        btns = 1'b1;
        cycle();
        cycle();
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL press_in_goal: got %0d expected 3", state); end
        #2 rst = 1'b1;
        #1;
        checks++; if (state !== 3'd0 || p1_ones !== 4'd0 || serve_dir !== 1'b0) begin errors++; $display("FAIL async_reset: got state %0d p1 %0d dir %0b expected 0 0 0", state, p1_ones, serve_dir); end
        checks++; if (play_en !== 1'b0 || puck_reset !== 1'b0 || winner !== 2'b00) begin errors++; $display("FAIL async_reset_flags: got %0b%0b%0b expected 0000", play_en, puck_reset, winner); end
        cycle();
        rst = 1'b0;
        repeat (5) cycle();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL held_after_reset: got %0d expected 0", state); end
        release_btn();
        press_hold();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL repress_after_reset: got %0d expected 1", state); end
        release_btn();
    endtask

    task automatic test_press_in_play();
        do_reset();
        start_play();
`ifdef MATCH_PAUSE_EN
        press_hold();
        checks++; if (state !== 3'd5 || play_en !== 1'b0) begin errors++; $display("FAIL pause_enter: got state %0d play_en %0b expected 5 0", state, play_en); end
        release_btn();
        goal_p1 = 1'b1;
        cycle();
        goal_p1 = 1'b0;
        checks++; if (state !== 3'd5 || p1_ones !== 4'd0) begin errors++; $display("FAIL pause_goal: got state %0d p1 %0d expected 5 0", state, p1_ones); end
        press_hold();
        checks++; if (state !== 3'd2 || play_en !== 1'b1 || puck_reset !== 1'b0) begin errors++; $display("FAIL pause_exit: got state %0d play_en %0b puck_reset %0b expected 2 1 0", state, play_en, puck_reset); end
        release_btn();
`else
        press_hold();
        checks++; if (state !== 3'd2 || play_en !== 1'b1) begin errors++; $display("FAIL press_in_play: got state %0d play_en %0b expected 2 1", state, play_en); end
        release_btn();
`endif
    endtask

    initial begin
        test_reset();
        test_serve();
        test_p1_match();
        test_bcd();
        test_both_goals();
        test_async_reset();
        test_press_in_play();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
